// File: rtl/player_step_ctrl_if.sv
// Wall-map query channel between the player step controller and the maze map.
// The controller drives request and cell; the map answers with a one-cycle ack.
interface player_step_ctrl_if #(
  parameter int CW = 4
);
  logic          wall_req;
  logic [CW-1:0] wall_x;
  logic [CW-1:0] wall_y;
  logic          wall_ack;
  logic          wall_hit;

  modport master (output wall_req, output wall_x, output wall_y,
                  input wall_ack, input wall_hit);
  modport slave  (input wall_req, input wall_x, input wall_y,
                  output wall_ack, output wall_hit);
endinterface

// File: rtl/player_step_ctrl.sv
// Player step controller: each rising edge of the divider wave runs one step that
// either turns the player or moves one cell after a wall-map check.
module player_step_ctrl #(
  parameter int MAZE_W    = 16,
  parameter int MAZE_H    = 16,
  parameter int CW        = 4,
  parameter int START_X   = 1,
  parameter int START_Y   = 1,
  parameter int START_DIR = 0
) (
  input  logic                clkin,
  input  logic                resetn,
  input  logic                rate_clk,
  input  logic [3:0]          keys_n,
  player_step_ctrl_if.master  wall,
  output logic [CW-1:0]       pos_x,
  output logic [CW-1:0]       pos_y,
  output logic [1:0]          heading,
  output logic                redraw
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DECODE   = 3'd1,
    QUERY    = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4
  } state_t;

  // One extra bit lets underflow below 0 wrap to a value that fails the range test.
  localparam logic [CW:0] MAX_X = (CW+1)'(MAZE_W);
  localparam logic [CW:0] MAX_Y = (CW+1)'(MAZE_H);
  localparam logic [CW:0] ONE   = {{CW{1'b0}}, 1'b1};

  state_t        state_q;
  logic          rate_prev_q;
  logic          pending_q;
  logic [3:0]    keys_q;
  logic [CW-1:0] pos_x_q;
  logic [CW-1:0] pos_y_q;
  logic [1:0]    heading_q;
  logic          wall_req_q;
  logic [CW-1:0] wall_x_q;
  logic [CW-1:0] wall_y_q;
  logic          redraw_q;

  logic          tick_s;
  logic          move_s;
  logic          turn_l_s;
  logic          turn_r_s;
  logic          in_range_s;
  logic [1:0]    dir_s;
  logic [CW:0]   tgt_x_d;
  logic [CW:0]   tgt_y_d;

  assign tick_s = rate_clk & ~rate_prev_q;

  // Decode captured keys and compute the move target cell.
  always_comb begin
    move_s   = keys_q[3] ^ keys_q[2];
    turn_l_s = keys_q[1] & ~keys_q[0];
    turn_r_s = keys_q[0] & ~keys_q[1];
    if (keys_q[3]) begin
      dir_s = heading_q;
    end else begin
      dir_s = heading_q ^ 2'd2;
    end
    tgt_x_d = {1'b0, pos_x_q};
    tgt_y_d = {1'b0, pos_y_q};
    case (dir_s)
      2'd0:    tgt_y_d = {1'b0, pos_y_q} - ONE;
      2'd1:    tgt_x_d = {1'b0, pos_x_q} + ONE;
      2'd2:    tgt_y_d = {1'b0, pos_y_q} + ONE;
      2'd3:    tgt_x_d = {1'b0, pos_x_q} - ONE;
      default: tgt_x_d = {1'b0, pos_x_q};
    endcase
    in_range_s = (tgt_x_d < MAX_X) && (tgt_y_d < MAX_Y);
  end

  // Step sequencer with registered position, heading and query outputs.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rate_prev_q <= 1'b0;
      pending_q   <= 1'b0;
      keys_q      <= 4'd0;
      pos_x_q     <= CW'(START_X);
      pos_y_q     <= CW'(START_Y);
      heading_q   <= 2'(START_DIR);
      wall_req_q  <= 1'b0;
      wall_x_q    <= {CW{1'b0}};
      wall_y_q    <= {CW{1'b0}};
      redraw_q    <= 1'b0;
    end else begin
      rate_prev_q <= rate_clk;
      redraw_q    <= 1'b0;
      if (tick_s && (state_q != IDLE)) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (tick_s || pending_q) begin
            keys_q    <= ~keys_n;
            pending_q <= 1'b0;
            state_q   <= DECODE;
          end
        end
        DECODE: begin
          if (move_s) begin
            if (in_range_s) begin
              wall_x_q   <= tgt_x_d[CW-1:0];
              wall_y_q   <= tgt_y_d[CW-1:0];
              wall_req_q <= 1'b1;
              state_q    <= QUERY;
            end else begin
              state_q <= IDLE;
            end
          end else if (turn_l_s) begin
            heading_q <= heading_q - 2'd1;
            redraw_q  <= 1'b1;
            state_q   <= DONE;
          end else if (turn_r_s) begin
            heading_q <= heading_q + 2'd1;
            redraw_q  <= 1'b1;
            state_q   <= DONE;
          end else begin
            state_q <= IDLE;
          end
        end
        QUERY: state_q <= WAIT_ACK;
        WAIT_ACK: begin
          if (wall.wall_ack) begin
            wall_req_q <= 1'b0;
            if (!wall.wall_hit) begin
              pos_x_q  <= wall_x_q;
              pos_y_q  <= wall_y_q;
              redraw_q <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: begin
          wall_req_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign wall.wall_req = wall_req_q;
  assign wall.wall_x   = wall_x_q;
  assign wall.wall_y   = wall_y_q;
  assign pos_x         = pos_x_q;
  assign pos_y         = pos_y_q;
  assign heading       = heading_q;
  assign redraw        = redraw_q;

endmodule

// File: doc/player_step_ctrl.md
Name: player_step_ctrl

Overview:
- Consumes the slow square wave from the 50 MHz rate divider and turns each rising edge into one player-update step.
- On each step, samples the push-buttons and either rotates the player heading or attempts a one-cell move.
- Moves are checked against the maze wall map through a request/acknowledge query.
- Drives the player cell position and heading to the raycast renderer, plus a one-cycle redraw pulse.

Parameters:
- MAZE_W, 16, maze width in cells; x valid range 0..MAZE_W-1.
- MAZE_H, 16, maze height in cells; y valid range 0..MAZE_H-1.
- CW, 4, coordinate width in bits; must satisfy 2^CW >= max(MAZE_W, MAZE_H).
- START_X, 1, x after reset.
- START_Y, 1, y after reset.
- START_DIR, 0, heading after reset (0=N, 1=E, 2=S, 3=W).

Ports:
- clkin  in  1  50 MHz system clock
- resetn  in  1  asynchronous active-low reset
- rate_clk  in  1  divider square-wave output, generated in the clkin domain
- keys_n  in  4  active-low buttons: [3]=fwd, [2]=back, [1]=turn left, [0]=turn right
- wall_req  out  1  wall query request
- wall_x  out  CW  queried cell x
- wall_y  out  CW  queried cell y
- wall_ack  in  1  query response valid, single cycle
- wall_hit  in  1  1 = queried cell is a wall; valid only when wall_ack=1
- pos_x  out  CW  player cell x
- pos_y  out  CW  player cell y
- heading  out  2  player heading
- redraw  out  1  one-cycle pulse when pos_x, pos_y or heading changed

Behaviour:
- Reset (asynchronous on resetn=0) forces:
  - pos_x=START_X, pos_y=START_Y, heading=START_DIR
  - wall_req=0, wall_x=0, wall_y=0, redraw=0
  - FSM to IDLE, pending=0, rate_prev=0
- Tick detect:
  - rate_prev is a register of rate_clk.
  - tick = rate_clk & ~rate_prev (exactly one cycle per divider rising edge).
- Key sampling: keys_n is inverted and captured into a key register only in IDLE, on a tick; no other debounce (the tick period filters bounce).
- Command priority (evaluated on the captured keys):
  - fwd and back both pressed: no move; turns are still considered.
  - otherwise fwd, then back, then left, then right.
  - left and right both pressed with no move: no action.
  - no keys: no action, no redraw.
- FSM states: IDLE, DECODE, QUERY, WAIT_ACK, DONE.
  - IDLE: on tick (or pending=1), capture keys, clear pending, go to DECODE.
  - DECODE, turn left: heading <= heading-1 mod 4, go to DONE.
  - DECODE, turn right: heading <= heading+1 mod 4, go to DONE.
  - DECODE, move: compute target; N: y-1, E: x+1, S: y+1, W: x-1; back uses the opposite delta.
    - Target outside 0..MAZE_W-1 or 0..MAZE_H-1 (including underflow below 0): blocked, go to IDLE, no query, no redraw.
    - Otherwise load wall_x/wall_y with the target, go to QUERY.
  - DECODE, no action: go to IDLE.
  - QUERY: wall_req=1, go to WAIT_ACK.
  - WAIT_ACK: wall_req stays 1 until the cycle wall_ack=1; it then drops to 0 in the next cycle.
    - wall_hit=0: commit target to pos_x/pos_y, go to DONE.
    - wall_hit=1: go to IDLE, no redraw.
    - No timeout.
  - DONE: redraw=1 for exactly one cycle, go to IDLE.
- Tick while not IDLE: sets pending=1. Further ticks while pending=1 are dropped (at most one queued step).
- Latency, tick to redraw:
  - turn: 3 cycles (IDLE, DECODE, DONE).
  - move: 4 + N cycles, where N = cycles from wall_req rising to wall_ack.
- Outputs change only at committed updates; pos_x, pos_y and heading are registered.
- wall_x/wall_y hold their last value when wall_req=0.
- Reset asserted mid-query: wall_req drops immediately (asynchronous) and no position commit happens.

Test Plan:
- Reset, then hold rate_clk=0 for 100 cycles -> pos=(1,1), heading=0, wall_req=0, redraw=0 throughout.
- keys_n=4'b1110, one rate_clk rising edge -> heading=1 and redraw pulses once, 3 cycles after the edge; a second edge -> heading=2; four edges in total -> heading wraps to 0.
- Heading E, keys_n=4'b0111, edge, responder acks after 2 cycles with wall_hit=0 -> wall_x=2, wall_y=1, pos becomes (2,1), one redraw; repeat with wall_hit=1 -> pos unchanged, no redraw.
- pos=(0,1), heading W, fwd pressed, edge -> wall_req never asserts, pos stays (0,1), no redraw.
- Responder delays ack 20 cycles while 3 rate_clk edges arrive -> exactly one extra step executes after the first completes, and wall_req is held high for the full wait.
- resetn pulled low while WAIT_ACK -> wall_req=0 at once, pos returns to (START_X, START_Y); a late wall_ack after release has no effect.
